// File: rtl/vote_collector_pkg.sv
// Shared definitions for the ballot-collection block: ID width, voter weights,
// default population sizes and the session state encoding.
package vote_collector_pkg;
    localparam int ID_W       = 6;
    localparam int TALLY_W    = 8;
    localparam int NP_N_DEF   = 32;
    localparam int VIP_N_DEF  = 8;
    localparam int THRESH_DEF = 32;

    localparam logic [TALLY_W-1:0] W_NP   = 8'd1;
    localparam logic [TALLY_W-1:0] W_VIP  = 8'd4;
    localparam logic [TALLY_W-1:0] W_VVIP = 8'd16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;
endpackage

// File: rtl/vote_weight.sv
// Maps a voter ID to its legality and ballot weight; purely combinational so
// any ballot source or checker can reuse it.
module vote_weight
    import vote_collector_pkg::*;
#(
    parameter int NP_N  = NP_N_DEF,
    parameter int VIP_N = VIP_N_DEF
) (
    input  logic [ID_W-1:0]    in_id,
    output logic               legal,
    output logic [TALLY_W-1:0] weight
);
    localparam logic [ID_W-1:0] VIP_LO  = ID_W'(NP_N);
    localparam logic [ID_W-1:0] VVIP_ID = ID_W'(NP_N + VIP_N);

    always_comb begin
        legal  = 1'b1;
        weight = W_NP;
        if (in_id < VIP_LO) begin
            weight = W_NP;
        end else if (in_id < VVIP_ID) begin
            weight = W_VIP;
        end else if (in_id == VVIP_ID) begin
            weight = W_VVIP;
        end else begin
            legal  = 1'b0;
            weight = '0;
        end
    end
endmodule

// File: rtl/vote_collector.sv
// Session FSM, voted bitmap and weighted tally; latches the pass/fail decision
// when the session is closed.
module vote_collector
    import vote_collector_pkg::*;
#(
    parameter int THRESH = THRESH_DEF,
    parameter int NP_N   = NP_N_DEF,
    parameter int VIP_N  = VIP_N_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               close,
    input  logic               in_valid,
    input  logic [ID_W-1:0]    in_id,
    output logic               in_ready,
    output logic               busy,
    output logic               done,
    output logic               res,
    output logic [TALLY_W-1:0] tally,
    output logic               dup_err,
    output logic               bad_id
);
    localparam int                 NV       = NP_N + VIP_N + 1;
    localparam logic [TALLY_W-1:0] THRESH_V = TALLY_W'(THRESH);

    state_t             state_reg;
    logic [NV-1:0]      voted_reg;
    logic [NV-1:0]      set_vec;
    logic [TALLY_W-1:0] tally_reg;
    logic [TALLY_W-1:0] tally_next;
    logic               res_reg;
    logic               dup_reg;
    logic               bad_reg;
    logic               legal;
    logic [TALLY_W-1:0] weight;
    logic               xfer;
    logic               already;
    logic               accept;

    vote_weight #(.NP_N(NP_N), .VIP_N(VIP_N)) u_weight (
        .in_id  (in_id),
        .legal  (legal),
        .weight (weight)
    );

    // Bitmap is only indexed once the ID is known legal, so no out-of-range read.
    assign xfer       = in_valid && (state_reg == S_COLLECT);
    assign already    = legal && voted_reg[in_id];
    assign accept     = xfer && legal && !already;
    assign tally_next = accept ? (tally_reg + weight) : tally_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NV; gi++) begin : g_set
            assign set_vec[gi] = accept && (in_id == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            voted_reg <= '0;
            tally_reg <= '0;
            res_reg   <= 1'b0;
            dup_reg   <= 1'b0;
            bad_reg   <= 1'b0;
        end else begin
            dup_reg <= xfer && already;
            bad_reg <= xfer && !legal;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_COLLECT;
                        voted_reg <= '0;
                        tally_reg <= '0;
                    end
                end
                S_COLLECT: begin
                    voted_reg <= voted_reg | set_vec;
                    tally_reg <= tally_next;
                    // A ballot arriving with close counts toward the decision.
                    if (close) begin
                        state_reg <= S_DONE;
                        res_reg   <= (tally_next > THRESH_V);
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_reg <= S_COLLECT;
                        voted_reg <= '0;
                        tally_reg <= '0;
                        res_reg   <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign in_ready = (state_reg == S_COLLECT);
    assign busy     = (state_reg == S_COLLECT);
    assign done     = (state_reg == S_DONE);
    assign res      = res_reg;
    assign tally    = tally_reg;
    assign dup_err  = dup_reg;
    assign bad_id   = bad_reg;
endmodule
